rv_mem_port: RTL and testbench

//  Parametrised memory-port controller between the multicycle RV32 core and a wait-state memory/bus.

---
 rtl/rv_mem_pkg.sv | 43 ++++
 rtl/rv_load_align.sv | 35 +++
 rtl/rv_mem_port.sv | 148 ++++++++++++++
 tb/tb_rv_mem_port.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared encodings and helpers for the RV32 memory-port controller.
// Size codes, FSM states, byte-enable generation and store-lane replication.
package rv_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RDWAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_B:    return 4'b0001 << offset;
            SZ_H:    return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    // Size code 3 is reserved, so it is rejected the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_B:    return {4{data[7:0]}};
            SZ_H:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/rv_load_align.sv
// Load-lane alignment: shifts the addressed byte/half down to bit 0,
// then sign- or zero-extends it according to the access size.
module rv_load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic        fill;

    assign shifted = rdata >> {offset, 3'b000};

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        result = shifted;
        fill   = 1'b0;
        case (size)
            SZ_B: begin
                fill   = ~is_unsigned & shifted[7];
                result = {{24{fill}}, shifted[7:0]};
            end
            SZ_H: begin
                fill   = ~is_unsigned & shifted[15];
                result = {{16{fill}}, shifted[15:0]};
            end
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/rv_mem_port.sv
// Memory-port controller: req/gnt/rvalid handshake, byte strobes, load alignment and core stall.
// Optional bus watchdog enabled by defining RV_MEM_TIMEOUT_EN.
module rv_mem_port
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [1:0]        core_size,
    input  logic              core_unsigned,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              core_done,
    output logic              core_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] load_result;
    logic              capture;
    logic              wd_expired;

    rv_load_align u_align (
        .rdata       (mem_rdata),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (load_result)
    );

`ifdef RV_MEM_TIMEOUT_EN
    logic [15:0] wd_cnt_q;

    // IDLE always precedes REQ, so clearing while idle clears on entry to REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd_cnt_q <= '0;
        else if (state_q == ST_IDLE)
            wd_cnt_q <= '0;
        else if (state_q == ST_REQ || state_q == ST_RDWAIT)
            wd_cnt_q <= wd_cnt_q + 16'd1;
    end

    assign wd_expired = (state_q == ST_REQ || state_q == ST_RDWAIT) &&
                        (wd_cnt_q + 16'd1 == 16'(TIMEOUT_CYC));
`else
    assign wd_expired = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            size_q  <= SZ_B;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else if (state_q == ST_IDLE && core_req) begin
            addr_q  <= core_addr;
            size_q  <= core_size;
            we_q    <= core_we;
            uns_q   <= core_unsigned;
            wdata_q <= core_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata_q <= '0;
        else if (capture)
            rdata_q <= load_result;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core_req)
                    state_d = is_misaligned(core_size, core_addr[1:0]) ? ST_ERR : ST_REQ;
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else if (mem_rvalid) begin
                        capture = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_RDWAIT: begin
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are gated by the REQ state so they fall with the async reset.
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? gen_be(size_q, addr_q[1:0]) : 4'b0000;
    assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = mem_req ? replicate_store(size_q, wdata_q) : '0;

    assign core_rdata = rdata_q;
    assign core_done  = (state_q == ST_DONE);
    assign core_err   = (state_q == ST_ERR);
    assign core_stall = (state_q == ST_REQ) || (state_q == ST_RDWAIT) ||
                        (state_q == ST_IDLE && core_req);

endmodule

// File: tb/tb_rv_mem_port.sv
// Directed self-checking bench for rv_mem_port: stores, loads, misalignment, reset abort
// and, when RV_MEM_TIMEOUT_EN is defined, the bus watchdog.
module tb_rv_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [1:0]  core_size = 2'd0;
    logic        core_unsigned = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        core_done;
    logic        core_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rv_mem_port #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_req      (core_req),
        .core_we       (core_we),
        .core_size     (core_size),
        .core_unsigned (core_unsigned),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .core_done     (core_done),
        .core_err      (core_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one core access starting at a falling edge. gnt is given on the gnt_dly-th
    // REQ cycle (0 = never); read data arrives rv_dly cycles after gnt.
    task automatic run_access(
        input  logic        we,
        input  logic [1:0]  sz,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  int          gnt_dly,
        input  int          rv_dly,
        input  logic [31:0] rd,
        output int          done_cyc,
        output int          stall_cyc,
        output int          req_cyc,
        output logic        err_seen,
        output logic [3:0]  be_seen,
        output logic        we_seen,
        output logic [31:0] wd_seen,
        output logic [31:0] addr_seen,
        output logic        addr_stable,
        output logic [31:0] rdata_seen
    );
        int          gnt_at;
        logic [31:0] first_addr;
        done_cyc    = -1;
        stall_cyc   = 0;
        req_cyc     = 0;
        err_seen    = 1'b0;
        be_seen     = '0;
        we_seen     = 1'b0;
        wd_seen     = '0;
        addr_seen   = '0;
        addr_stable = 1'b1;
        rdata_seen  = '0;
        gnt_at      = -1;
        first_addr  = '0;
        core_req      = 1'b1;
        core_we       = we;
        core_size     = sz;
        core_unsigned = uns;
        core_addr     = addr;
        core_wdata    = wd;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (mem_req) begin
                req_cyc++;
                if (req_cyc == 1)
                    first_addr = mem_addr;
                else if (mem_addr !== first_addr)
                    addr_stable = 1'b0;
                if (req_cyc == gnt_dly) begin
                    mem_gnt   = 1'b1;
                    gnt_at    = cyc;
                    be_seen   = mem_be;
                    we_seen   = mem_we;
                    wd_seen   = mem_wdata;
                    addr_seen = mem_addr;
                    if (!we && rv_dly == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rd;
                    end
                end
            end else if (!we && gnt_at > 0 && cyc == gnt_at + rv_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            #1;
            if (core_stall)
                stall_cyc++;
            if (core_done || core_err) begin
                done_cyc   = cyc;
                err_seen   = core_err;
                rdata_seen = core_rdata;
                break;
            end
            @(negedge clk);
        end
        core_req   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
    endtask

    int          done_cyc, stall_cyc, req_cyc;
    logic        err_seen, we_seen, addr_stable;
    logic [3:0]  be_seen;
    logic [31:0] wd_seen, addr_seen, rdata_seen;

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, core_stall}, 32'd0);
        check("rst_done_err", {30'd0, core_done, core_err}, 32'd0);
        check("rst_rdata", core_rdata, 32'h0);
        check("rst_bus", {mem_be, 27'd0, mem_we} | mem_addr | mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // SW 0xDEADBEEF @0x104, gnt on third REQ cycle
        run_access(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 3, 0, 32'h0,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("sw_done_cyc", 32'(done_cyc), 32'd5);
        check("sw_stall_cyc", 32'(stall_cyc), 32'd4);
        check("sw_req_cyc", 32'(req_cyc), 32'd3);
        check("sw_be", {28'd0, be_seen}, 32'hF);
        check("sw_we", {31'd0, we_seen}, 32'd1);
        check("sw_addr", addr_seen, 32'h104);
        check("sw_addr_stable", {31'd0, addr_stable}, 32'd1);
        check("sw_wdata", wd_seen, 32'hDEADBEEF);
        check("sw_err", {31'd0, err_seen}, 32'd0);

        // LB @0x103, gnt and rvalid together
        run_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 0, 32'h80112233,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("lb_done_cyc", 32'(done_cyc), 32'd3);
        check("lb_be", {28'd0, be_seen}, 32'h8);
        check("lb_we", {31'd0, we_seen}, 32'd0);
        check("lb_addr", addr_seen, 32'h100);
        check("lb_rdata", rdata_seen, 32'hFFFFFF80);

        run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 0, 32'h80112233,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("lbu_rdata", rdata_seen, 32'h00000080);

        // LH @0x102, rvalid two cycles after gnt
        run_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1, 2, 32'h80017FFF,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("lh_done_cyc", 32'(done_cyc), 32'd5);
        check("lh_req_cyc", 32'(req_cyc), 32'd1);
        check("lh_be", {28'd0, be_seen}, 32'hC);
        check("lh_rdata", rdata_seen, 32'hFFFF8001);

        run_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1, 2, 32'h80017FFF,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("lhu_rdata", rdata_seen, 32'h00008001);
        check("rdata_hold", core_rdata, 32'h00008001);

        // LW @0x101 is misaligned
        run_access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1, 0, 32'h12345678,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("lw_mis_err", {31'd0, err_seen}, 32'd1);
        check("lw_mis_cyc", 32'(done_cyc), 32'd2);
        check("lw_mis_noreq", 32'(req_cyc), 32'd0);
        check("lw_mis_rdata", rdata_seen, 32'h00008001);
        check("err_one_cycle", {31'd0, core_err}, 32'd0);

        // SH @0x001 and reserved size 3 are rejected
        run_access(1'b1, 2'd1, 1'b0, 32'h001, 32'h1234, 1, 0, 32'h0,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("sh_mis_err", {31'd0, err_seen}, 32'd1);
        check("sh_mis_noreq", 32'(req_cyc), 32'd0);
        run_access(1'b0, 2'd3, 1'b0, 32'h000, 32'h0, 1, 0, 32'h0,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("sz3_err", {31'd0, err_seen}, 32'd1);

        // SB 0xA5 @0x002, plus SH 0xBEEF @0x006
        run_access(1'b1, 2'd0, 1'b0, 32'h002, 32'h000000A5, 1, 0, 32'h0,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("sb_be", {28'd0, be_seen}, 32'h4);
        check("sb_wdata", wd_seen, 32'hA5A5A5A5);
        check("sb_addr", addr_seen, 32'h000);
        check("sb_done_cyc", 32'(done_cyc), 32'd3);
        run_access(1'b1, 2'd1, 1'b0, 32'h006, 32'h1234BEEF, 2, 0, 32'h0,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("sh_be", {28'd0, be_seen}, 32'hC);
        check("sh_wdata", wd_seen, 32'hBEEFBEEF);
        check("sh_addr", addr_seen, 32'h004);

        // Reset while in RDWAIT
        core_req = 1'b1; core_we = 1'b0; core_size = 2'd2; core_unsigned = 1'b0; core_addr = 32'h200;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rdwait_stall", {31'd0, core_stall}, 32'd1);
        reset = 1'b1;
        core_req = 1'b0;
        #1;
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("abort_stall", {31'd0, core_stall}, 32'd0);
        check("abort_done", {31'd0, core_done}, 32'd0);
        check("abort_rdata", core_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("late_rvalid_done", {31'd0, core_done}, 32'd0);
        check("late_rvalid_rdata", core_rdata, 32'h0);
        @(negedge clk);

`ifdef RV_MEM_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYC=8 and gnt never given
        run_access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0, 0, 32'h0,
                   done_cyc, stall_cyc, req_cyc, err_seen, be_seen, we_seen, wd_seen, addr_seen, addr_stable, rdata_seen);
        check("wd_err", {31'd0, err_seen}, 32'd1);
        check("wd_req_cyc", 32'(req_cyc), 32'd8);
        check("wd_err_cyc", 32'(done_cyc), 32'd10);
        check("wd_mem_req_low", {31'd0, mem_req}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
